// File: rtl/proc_isa_pkg.sv
// Instruction-set constants and feeder FSM encoding for the 16-bit bus processor.
// Shared by the instruction feeder RTL and its bench.
package proc_isa_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Field positions inside a program word: opcode | X | Y | unused.
  localparam int OP_HI = 15;
  localparam int OP_LO = 13;
  localparam int X_HI  = 12;
  localparam int X_LO  = 10;
  localparam int Y_HI  = 9;
  localparam int Y_LO  = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH_I   = 3'd1,
    ST_LATCH_I   = 3'd2,
    ST_FETCH_M   = 3'd3,
    ST_LATCH_M   = 3'd4,
    ST_ISSUE     = 3'd5,
    ST_WAIT_DONE = 3'd6,
    ST_HALTED    = 3'd7
  } feeder_state_e;

  function automatic logic [2:0] opcode_of(input logic [15:0] word);
    return word[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/done_timer.sv
// Saturating cycle counter that flags when the processor has taken too long
// to raise Done for the instruction currently issued.
module done_timer #(
  parameter int DONE_TMO = 15
) (
  input  logic clk,
  input  logic Resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (DONE_TMO < 1) ? 1 : $clog2(DONE_TMO + 1);
  localparam logic [CW-1:0] TMO = CW'(DONE_TMO);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != TMO)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == TMO);

endmodule

// File: rtl/instr_feeder.sv
// Fetches program words from a synchronous ROM and issues them to the bus
// processor one at a time, holding the mvi immediate on DIN while it runs.
module instr_feeder
  import proc_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int LAST_ADDR = 255,
  parameter int DONE_TMO  = 15
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              Start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [15:0]       icount,
  output logic [2:0]        dbg_state
);

  // One extra bit so stepping past the last address is seen as "beyond the
  // end" rather than wrapping back to address 0.
  localparam logic [ADDR_W:0] LAST_W = (ADDR_W + 1)'(LAST_ADDR);

  feeder_state_e     state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       imm_q, imm_d;
  logic [15:0]       din_q, din_d;
  logic              run_q, run_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic [15:0]       icount_q, icount_d;

  logic              timer_clear;
  logic              timer_en;
  logic              timer_expired;
  logic              instr_is_mvi;
  logic [2:0]        fetched_op;
  logic [ADDR_W:0]   pc_next_w;

  assign instr_is_mvi = (opcode_of(instr_q) == OP_MVI);
  assign fetched_op   = opcode_of(mem_data);

  done_timer #(
    .DONE_TMO (DONE_TMO)
  ) u_done_timer (
    .clk     (clk),
    .Resetn  (Resetn),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imm_d       = imm_q;
    din_d       = din_q;
    err_d       = err_q;
    icount_d    = icount_q;
    timer_clear = 1'b1;
    timer_en    = 1'b0;
    pc_next_w   = {1'b0, pc_q} + (instr_is_mvi ? (ADDR_W + 1)'(2) : (ADDR_W + 1)'(1));

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          state_d  = ST_FETCH_I;
          pc_d     = '0;
          err_d    = 1'b0;
          icount_d = '0;
        end
      end
      ST_FETCH_I: state_d = ST_LATCH_I;
      ST_LATCH_I: begin
        instr_d = mem_data;
        if (fetched_op == OP_HALT) begin
          state_d = ST_HALTED;
        end else if ((fetched_op == OP_MVI) && ({1'b0, pc_q} == LAST_W)) begin
          // The immediate would sit past the end of the program.
          err_d   = 1'b1;
          state_d = ST_HALTED;
        end else if (fetched_op == OP_MVI) begin
          state_d = ST_FETCH_M;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_FETCH_M: state_d = ST_LATCH_M;
      ST_LATCH_M: begin
        imm_d   = mem_data;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        din_d   = instr_q;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        din_d       = instr_is_mvi ? imm_q : instr_q;
        timer_clear = 1'b0;
        timer_en    = 1'b1;
        if (Done) begin
          timer_clear = 1'b1;
          pc_d        = pc_next_w[ADDR_W-1:0];
          if (icount_q != 16'hFFFF) begin
            icount_d = icount_q + 16'd1;
          end
          state_d = (pc_next_w > LAST_W) ? ST_HALTED : ST_FETCH_I;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Run and DIN trail the ISSUE state by one cycle; the ROM strobe is
    // decoded from the next state so it lines up with FETCH_I/FETCH_M.
    run_d      = (state_q == ST_ISSUE);
    mem_rd_d   = (state_d == ST_FETCH_I) || (state_d == ST_FETCH_M);
    mem_addr_d = mem_addr_q;
    if (state_d == ST_FETCH_I) begin
      mem_addr_d = pc_d;
    end else if (state_d == ST_FETCH_M) begin
      mem_addr_d = pc_q + ADDR_W'(1);
    end
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_HALTED);
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      imm_q      <= '0;
      din_q      <= '0;
      run_q      <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      icount_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      din_q      <= din_d;
      run_q      <= run_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
      icount_q   <= icount_d;
    end
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign DIN       = din_q;
  assign Run       = run_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign err       = err_q;
  assign icount    = icount_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: ROM and processor responder models, a program-level
// model of what must be fetched and issued, and a per-cycle compare process.
module tb_instr_feeder;
  import proc_isa_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int LAST_ADDR = 3;
  localparam int DONE_TMO  = 15;

  localparam logic [15:0] W_MV   = 16'h0400;  // mv  R1,R0
  localparam logic [15:0] W_MVI  = 16'h2800;  // mvi R2
  localparam logic [15:0] W_IMM  = 16'h00A5;
  localparam logic [15:0] W_ADD  = 16'h4A80;  // add R2,R5
  localparam logic [15:0] W_HALT = 16'hE000;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic Resetn = 1'b0;
  logic Start  = 1'b0;
  always #5 clk = ~clk;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data = 16'h0000;
  logic [15:0]       DIN;
  logic              Run;
  logic              Done;
  logic [ADDR_W-1:0] pc;
  logic              busy, halted, err;
  logic [15:0]       icount;
  logic [2:0]        dbg_state;

  instr_feeder #(
    .ADDR_W    (ADDR_W),
    .LAST_ADDR (LAST_ADDR),
    .DONE_TMO  (DONE_TMO)
  ) dut (
    .clk       (clk),
    .Resetn    (Resetn),
    .Start     (Start),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .DIN       (DIN),
    .Run       (Run),
    .Done      (Done),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .err       (err),
    .icount    (icount),
    .dbg_state (dbg_state)
  );

  // ---------------- ROM and processor models ----------------
  logic [15:0] rom [0:255];
  always @(posedge clk) if (mem_rd) mem_data <= rom[mem_addr];

  int   done_delay = 1;  // cycles from Run to Done; 0 = never respond
  int   done_cnt   = 0;
  logic done_model = 1'b0;
  logic done_force = 1'b0;
  assign Done = done_model | done_force;

  always @(posedge clk) begin
    done_model <= 1'b0;
    if (Run) done_cnt = done_delay;
    if (done_cnt > 0) begin
      done_cnt = done_cnt - 1;
      if (done_cnt == 0) done_model <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0]       exp_q[$];       // words expected with each Run
  logic [15:0]       exp_hold_q[$];  // DIN expected after Run until Done
  logic [ADDR_W-1:0] exp_addr_q[$];  // ROM addresses expected on mem_rd
  int e_pc, e_cnt;
  bit e_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Walk the program from address 0 using the ISA rules and record what the
  // feeder must fetch and issue and where it must end up.
  task automatic model_program(input bit never_done);
    int p;
    int step;
    logic [15:0] w;
    exp_q.delete();
    exp_hold_q.delete();
    exp_addr_q.delete();
    e_cnt = 0;
    e_err = 1'b0;
    p = 0;
    for (int k = 0; k < 300; k++) begin
      w = rom[p];
      exp_addr_q.push_back(ADDR_W'(p));
      if (w[15:13] == 3'b111) break;
      if (w[15:13] == 3'b001) begin
        if (p == LAST_ADDR) begin
          e_err = 1'b1;
          break;
        end
        exp_addr_q.push_back(ADDR_W'(p + 1));
        exp_q.push_back(w);
        exp_hold_q.push_back(rom[p + 1]);
        step = 2;
      end else begin
        exp_q.push_back(w);
        exp_hold_q.push_back(w);
        step = 1;
      end
      if (never_done) begin
        e_err = 1'b1;
        break;
      end
      p = p + step;
      e_cnt++;
      if (p > LAST_ADDR) break;
    end
    e_pc = p;
  endtask

  // ---------------- compare process ----------------
  bit          chk_en      = 1'b0;
  bit          start_arm   = 1'b0;
  bit          waiting     = 1'b0;
  int          cyc         = 0;
  int          fetch_entry = 0;
  logic [15:0] hold_word   = '0;

  always @(negedge clk) begin
    logic [15:0] w;
    cyc++;
    if (chk_en) begin
      if (Start && start_arm) begin
        fetch_entry = cyc + 1;
        start_arm   = 1'b0;
      end
      if (mem_rd) begin
        if (exp_addr_q.size() == 0) check("fetch_extra", {24'd0, mem_addr}, 32'hFFFF_FFFF);
        else check("mem_addr", {24'd0, mem_addr}, {24'd0, exp_addr_q.pop_front()});
      end
      if (Run) begin
        if (exp_q.size() == 0) begin
          check("run_extra", {16'd0, DIN}, 32'hFFFF_FFFF);
        end else begin
          w         = exp_q.pop_front();
          hold_word = exp_hold_q.pop_front();
          check("run_din", {16'd0, DIN}, {16'd0, w});
          check("issue_latency", cyc - fetch_entry, (w[15:13] == 3'b001) ? 5 : 3);
          waiting = 1'b1;
        end
      end else if (waiting) begin
        check("din_hold", {16'd0, DIN}, {16'd0, hold_word});
        if (Done) begin
          waiting     = 1'b0;
          fetch_entry = cyc + 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_prog(input bit never_done);
    model_program(never_done);
    waiting   = 1'b0;
    start_arm = 1'b1;
    Start     = 1'b1;
    tick();
    Start     = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    int k;
    k = 0;
    while (halted !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check("halted_within_budget", {31'd0, halted}, 32'd1);
  endtask

  task automatic check_end();
    check("end_pc", {24'd0, pc}, e_pc);
    check("end_icount", {16'd0, icount}, e_cnt);
    check("end_err", {31'd0, err}, {31'd0, e_err});
    check("end_busy", {31'd0, busy}, 32'd0);
    check("issues_left", exp_q.size(), 0);
    check("fetches_left", exp_addr_q.size(), 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int k;
    for (int i = 0; i < 256; i++) rom[i] = W_HALT;

    // Reset state
    Resetn = 1'b0;
    repeat (3) tick();
    check("rst_run", {31'd0, Run}, 32'd0);
    check("rst_din", {16'd0, DIN}, 32'd0);
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_icount", {16'd0, icount}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    Resetn = 1'b1;
    chk_en = 1'b1;
    tick();

    // 1: mv then HALT, Done one cycle after Run
    rom[0] = W_MV; rom[1] = W_HALT; done_delay = 1;
    start_prog(1'b0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_halted(40);
    check_end();
    check("t1_pc", {24'd0, pc}, 32'd1);
    check("t1_icount", {16'd0, icount}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    done_force = 1'b1;  // stray Done while halted must not retire anything
    tick();
    done_force = 1'b0;
    tick();
    check("t1_stray_done", {16'd0, icount}, 32'd1);

    // 2: mvi with immediate, then HALT
    rom[0] = W_MVI; rom[1] = W_IMM; rom[2] = W_HALT; done_delay = 1;
    start_prog(1'b0);
    wait_halted(40);
    check_end();
    check("t2_pc", {24'd0, pc}, 32'd2);
    check("t2_din_imm", {16'd0, DIN}, {16'd0, W_IMM});

    // 3: add with Done three cycles after Run
    rom[0] = W_ADD; rom[1] = W_HALT; done_delay = 3;
    start_prog(1'b0);
    wait_halted(40);
    check_end();
    check("t3_icount", {16'd0, icount}, 32'd1);

    // 4: Done never arrives -> timeout; next Start clears err
    rom[0] = W_MV; rom[1] = W_HALT; done_delay = 0;
    start_prog(1'b1);
    wait_halted(60);
    check_end();
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    done_delay = 1;
    start_prog(1'b0);
    check("t4_err_cleared", {31'd0, err}, 32'd0);
    check("t4_halted_cleared", {31'd0, halted}, 32'd0);
    wait_halted(40);
    check_end();

    // 5: mvi at the last address errors without a Run; mv there runs off the end
    rom[0] = W_MV; rom[1] = W_MV; rom[2] = W_MV; rom[3] = W_MVI; done_delay = 1;
    start_prog(1'b0);
    wait_halted(60);
    check_end();
    check("t5a_err", {31'd0, err}, 32'd1);
    check("t5a_pc", {24'd0, pc}, 32'd3);
    check("t5a_icount", {16'd0, icount}, 32'd3);
    rom[3] = W_MV;
    start_prog(1'b0);
    wait_halted(60);
    check_end();
    check("t5b_pc", {24'd0, pc}, 32'd4);
    check("t5b_err", {31'd0, err}, 32'd0);
    check("t5b_halted", {31'd0, halted}, 32'd1);

    // 6: Start while busy ignored; reset in WAIT_DONE aborts the instruction
    rom[0] = W_MV; rom[1] = W_ADD; rom[2] = W_HALT; rom[3] = W_HALT; done_delay = 3;
    start_prog(1'b0);
    k = 0;
    while (!(Run === 1'b1 && pc === ADDR_W'(1)) && k < 40) begin
      tick();
      k++;
    end
    check("t6_second_run_seen", {31'd0, Run}, 32'd1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("t6_busy_start_pc", {24'd0, pc}, 32'd1);
    check("t6_busy_start_busy", {31'd0, busy}, 32'd1);
    check("t6_state_wait", {29'd0, dbg_state}, {29'd0, ST_WAIT_DONE});
    chk_en = 1'b0;
    Resetn = 1'b0;
    tick();
    check("t6_rst_run", {31'd0, Run}, 32'd0);
    check("t6_rst_din", {16'd0, DIN}, 32'd0);
    check("t6_rst_pc", {24'd0, pc}, 32'd0);
    check("t6_rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_icount", {16'd0, icount}, 32'd0);
    Resetn  = 1'b1;
    waiting = 1'b0;
    repeat (3) tick();
    chk_en = 1'b1;
    rom[1] = W_HALT; done_delay = 1;
    start_prog(1'b0);
    wait_halted(40);
    check_end();
    check("t6_recover_icount", {16'd0, icount}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
